// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the two-master data memory arbiter.
package data_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWN_CPU,
        OWN_AUX
    } owner_state_e;

    // Port indices, also used as the encoding of the last-served flag.
    localparam logic CPU = 1'b0;
    localparam logic AUX = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundles the CPU, auxiliary master and shared RAM signals around the arbiter.
interface data_mem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          aux_req;
    logic          aux_we;
    logic [AW-1:0] aux_addr;
    logic [DW-1:0] aux_wdata;
    logic          aux_gnt;
    logic          aux_rvalid;
    logic [DW-1:0] aux_rdata;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  aux_req, aux_we, aux_addr, aux_wdata,
        output aux_gnt, aux_rvalid, aux_rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Masters and RAM side.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output aux_req, aux_we, aux_addr, aux_wdata,
        input  aux_gnt, aux_rvalid, aux_rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/rd_return_tracker.sv
// Remembers which port issued a read so the RAM data one cycle later is flagged on that port.
module rd_return_tracker
    import data_mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic rd_issue,
    input  logic rd_port,
    output logic cpu_rvalid,
    output logic aux_rvalid
);

    logic valid_q;
    logic port_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            port_q  <= CPU;
        end else begin
            valid_q <= rd_issue;
            port_q  <= rd_port;
        end
    end

    assign cpu_rvalid = valid_q && (port_q == CPU);
    assign aux_rvalid = valid_q && (port_q == AUX);

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the CPU and auxiliary master onto one data RAM port with a bounded burst
// length, so neither master can starve the other beyond MAX_BURST consecutive grants.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                clk,
    input  logic                reset,
    data_mem_arbiter_if.slave   bus
);

    localparam int unsigned CntW = $clog2(MAX_BURST + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST);

    owner_state_e    state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            last_q, last_d;

    logic          sel_cpu, sel_aux;
    logic          gnt_cpu, gnt_aux;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          rd_issue;
    logic          rd_port;

    always_comb begin
        sel_cpu = 1'b0;
        sel_aux = 1'b0;
        unique case (state_q)
            OWN_CPU: begin
                // Owner keeps the port until the burst limit, and only yields then if the
                // other master is actually waiting.
                if (bus.cpu_req && (cnt_q < CntMax || !bus.aux_req)) begin
                    sel_cpu = 1'b1;
                end else if (bus.aux_req) begin
                    sel_aux = 1'b1;
                end
            end
            OWN_AUX: begin
                if (bus.aux_req && (cnt_q < CntMax || !bus.cpu_req)) begin
                    sel_aux = 1'b1;
                end else if (bus.cpu_req) begin
                    sel_cpu = 1'b1;
                end
            end
            default: begin
                if (bus.cpu_req && bus.aux_req) begin
                    sel_cpu = (last_q == AUX);
                    sel_aux = (last_q == CPU);
                end else begin
                    sel_cpu = bus.cpu_req;
                    sel_aux = bus.aux_req;
                end
            end
        endcase
    end

    // Grants are masked while reset is asserted so no transfer can leak through.
    assign gnt_cpu = sel_cpu & reset;
    assign gnt_aux = sel_aux & reset;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        if (sel_cpu) begin
            state_d = OWN_CPU;
            last_d  = CPU;
            if (state_q == OWN_CPU) begin
                cnt_d = (cnt_q < CntMax) ? cnt_q + 1'b1 : cnt_q;
            end else begin
                cnt_d = CntW'(1);
            end
        end else if (sel_aux) begin
            state_d = OWN_AUX;
            last_d  = AUX;
            if (state_q == OWN_AUX) begin
                cnt_d = (cnt_q < CntMax) ? cnt_q + 1'b1 : cnt_q;
            end else begin
                cnt_d = CntW'(1);
            end
        end else begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= AUX;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_cpu) begin
            mem_we    = bus.cpu_we;
            mem_addr  = bus.cpu_addr;
            mem_wdata = bus.cpu_wdata;
        end else if (gnt_aux) begin
            mem_we    = bus.aux_we;
            mem_addr  = bus.aux_addr;
            mem_wdata = bus.aux_wdata;
        end
    end

    assign rd_issue = (gnt_cpu && !bus.cpu_we) || (gnt_aux && !bus.aux_we);
    assign rd_port  = gnt_aux ? AUX : CPU;

    rd_return_tracker u_rd_return_tracker (
        .clk        (clk),
        .reset      (reset),
        .rd_issue   (rd_issue),
        .rd_port    (rd_port),
        .cpu_rvalid (bus.cpu_rvalid),
        .aux_rvalid (bus.aux_rvalid)
    );

    assign bus.cpu_gnt   = gnt_cpu;
    assign bus.aux_gnt   = gnt_aux;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.aux_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: expected grants per step, read returns via a scoreboard.
module tb_data_mem_arbiter;
    import data_mem_arbiter_pkg::*;

    localparam int unsigned AW        = 32;
    localparam int unsigned DW        = 32;
    localparam int unsigned MAX_BURST = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    data_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    data_mem_arbiter #(
        .AW        (AW),
        .DW        (DW),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
    } rd_exp_t;

    rd_exp_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [DW-1:0] ram_model(input logic [AW-1:0] a);
        case (a)
            32'h20:  return 32'h11;
            32'h24:  return 32'h22;
            default: return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca,
                         input logic [DW-1:0] cd, input logic ar, input logic aw,
                         input logic [AW-1:0] aa, input logic [DW-1:0] ad);
        bus.cpu_req   = cr;
        bus.cpu_we    = cw;
        bus.cpu_addr  = ca;
        bus.cpu_wdata = cd;
        bus.aux_req   = ar;
        bus.aux_we    = aw;
        bus.aux_addr  = aa;
        bus.aux_wdata = ad;
        // RAM answers the read issued last cycle.
        bus.mem_rdata = (sb.size() > 0) ? sb[0].data : DW'($urandom);
    endtask

    task automatic cycle(input string tag, input logic ecg, input logic eag);
        rd_exp_t       e;
        logic          ewe;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] ewd;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, ".cpu_rvalid"}, DW'(bus.cpu_rvalid), DW'(e.port == CPU));
            chk({tag, ".aux_rvalid"}, DW'(bus.aux_rvalid), DW'(e.port == AUX));
            if (e.port == CPU) chk({tag, ".cpu_rdata"}, bus.cpu_rdata, e.data);
            else               chk({tag, ".aux_rdata"}, bus.aux_rdata, e.data);
        end else begin
            chk({tag, ".cpu_rvalid"}, DW'(bus.cpu_rvalid), '0);
            chk({tag, ".aux_rvalid"}, DW'(bus.aux_rvalid), '0);
        end
        chk({tag, ".cpu_gnt"}, DW'(bus.cpu_gnt), DW'(ecg));
        chk({tag, ".aux_gnt"}, DW'(bus.aux_gnt), DW'(eag));
        ewe = 1'b0; eaddr = '0; ewd = '0;
        if (ecg) begin
            ewe = bus.cpu_we; eaddr = bus.cpu_addr; ewd = bus.cpu_wdata;
        end else if (eag) begin
            ewe = bus.aux_we; eaddr = bus.aux_addr; ewd = bus.aux_wdata;
        end
        chk({tag, ".mem_we"},    DW'(bus.mem_we), DW'(ewe));
        chk({tag, ".mem_addr"},  bus.mem_addr,    eaddr);
        chk({tag, ".mem_wdata"}, bus.mem_wdata,   ewd);
        if (ecg && !bus.cpu_we) sb.push_back('{port: CPU, data: ram_model(bus.cpu_addr)});
        if (eag && !bus.aux_we) sb.push_back('{port: AUX, data: ram_model(bus.aux_addr)});
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with both masters requesting: nothing may be granted.
        drive(1'b1, 1'b1, 32'h4, 32'h1, 1'b1, 1'b1, 32'h8, 32'h2);
        cycle("rst0", 1'b0, 1'b0);
        cycle("rst1", 1'b0, 1'b0);
        reset = 1'b1;

        // Both held: CPU for MAX_BURST reads, then AUX for MAX_BURST, then CPU again.
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b0, 32'h100 + 32'(i * 4), 32'h0, 1'b1, 1'b0, 32'h200 + 32'(i * 4), 32'h0);
            cycle($sformatf("burst%0d", i), (i < 8) || (i == 16), (i >= 8) && (i < 16));
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle("idle0", 1'b0, 1'b0);

        // Single CPU write from idle.
        drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle("cpu_wr", 1'b1, 1'b0);

        // AUX alone saturates its counter, then a CPU request wins immediately.
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h300 + 32'(i * 4), 32'(i));
            cycle($sformatf("aux%0d", i), 1'b0, 1'b1);
        end
        drive(1'b1, 1'b1, 32'h50, 32'h55, 1'b1, 1'b1, 32'h60, 32'h66);
        cycle("preempt", 1'b1, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle("idle1", 1'b0, 1'b0);

        // CPU read then AUX read: returns land on the right port one cycle each.
        drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle("rd_cpu", 1'b1, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0);
        cycle("rd_aux", 1'b0, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle("rd_ret", 1'b0, 1'b0);

        // Reset mid-burst with a read return pending.
        drive(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle("pre_rst", 1'b1, 1'b0);
        drive(1'b1, 1'b1, 32'h44, 32'h7, 1'b1, 1'b1, 32'h48, 32'h9);
        #1;
        reset = 1'b0;
        #1;
        chk("async.cpu_gnt",    DW'(bus.cpu_gnt),    '0);
        chk("async.aux_gnt",    DW'(bus.aux_gnt),    '0);
        chk("async.mem_we",     DW'(bus.mem_we),     '0);
        chk("async.cpu_rvalid", DW'(bus.cpu_rvalid), '0);
        chk("async.aux_rvalid", DW'(bus.aux_rvalid), '0);
        sb.delete();
        @(posedge clk);
        #1;
        cycle("rst_hold", 1'b0, 1'b0);
        reset = 1'b1;
        drive(1'b1, 1'b1, 32'h44, 32'h7, 1'b1, 1'b1, 32'h48, 32'h9);
        cycle("tie_after_rst", 1'b1, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle("idle2", 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
